// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with big-endian load extraction, stall/flush, misalign flag and retire counter
module mem_wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                in_reg_write,
    input  logic                in_mem_to_reg,
    input  logic [2:0]          in_load_type,
    input  logic [1:0]          in_addr_lo,
    input  logic [31:0]         in_alu_result,
    input  logic [31:0]         in_mem_rdata,
    input  logic [4:0]          in_dest_reg,
    input  logic                err_clr,
    output logic                wb_write_enb,
    output logic [4:0]          wb_write_reg,
    output logic [31:0]         wb_write_data,
    output logic                wb_valid,
    output logic                misalign_err,
    output logic [RETIRE_W-1:0] retire_count
);
    logic                valid_q, valid_d;
    logic                enb_q, enb_d;
    logic [4:0]          reg_q, reg_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;
    logic [RETIRE_W-1:0] cnt_q, cnt_d;
    logic                cap, is_b, is_bu, is_h, is_hu, is_w, misaligned;
    logic [31:0]         shifted, load_data;
    logic [15:0]         half;
    logic [7:0]          byte_v;

    // Decode the load, extract the addressed lane and resolve next WB state by priority rst > flush > stall > capture
    always_comb begin
        cap        = rst & !flush & !stall;
        is_b       = in_load_type == 3'd1;
        is_bu      = in_load_type == 3'd2;
        is_h       = in_load_type == 3'd3;
        is_hu      = in_load_type == 3'd4;
        is_w       = !(is_b | is_bu | is_h | is_hu);
        misaligned = in_valid & in_mem_to_reg & ((is_w & (in_addr_lo != 2'd0)) | ((is_h | is_hu) & in_addr_lo[0]));
        shifted    = in_mem_rdata << {in_addr_lo, 3'b000};
        byte_v     = shifted[31:24];
        half       = in_addr_lo[1] ? in_mem_rdata[15:0] : in_mem_rdata[31:16];
        load_data  = is_b  ? {{24{byte_v[7]}}, byte_v} :
                     is_bu ? {24'd0, byte_v} :
                     is_h  ? {{16{half[15]}}, half} :
                     is_hu ? {16'd0, half} : in_mem_rdata;
        valid_d    = !rst ? 1'b0 : flush ? 1'b0 : stall ? valid_q : in_valid;
        enb_d      = !rst ? 1'b0 : flush ? 1'b0 : stall ? enb_q :
                     in_valid & in_reg_write & (in_dest_reg != 5'd0) & !misaligned;
        reg_d      = !rst ? 5'd0 : cap ? in_dest_reg : reg_q;
        data_d     = !rst ? 32'd0 : cap ? (in_mem_to_reg ? load_data : in_alu_result) : data_q;
        err_d      = !rst ? 1'b0 : (cap & misaligned) | (err_q & !err_clr);
        cnt_d      = !rst ? '0 : cnt_q + RETIRE_W'(cap & in_valid);
    end

    // WB register bank
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        enb_q   <= enb_d;
        reg_q   <= reg_d;
        data_q  <= data_d;
        err_q   <= err_d;
        cnt_q   <= cnt_d;
    end

    assign wb_valid      = valid_q;
    assign wb_write_enb  = enb_q;
    assign wb_write_reg  = reg_q;
    assign wb_write_data = data_q;
    assign misalign_err  = err_q;
    assign retire_count  = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage with a 4-bit retire counter
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_reg_write, in_mem_to_reg, err_clr;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result, in_mem_rdata;
    logic [4:0]  in_dest_reg;
    logic        wb_write_enb, wb_valid, misalign_err;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [3:0]  retire_count;
    int          checks = 0;
    int          failures = 0;

    mem_wb_stage #(.RETIRE_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_load_type(in_load_type), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_dest_reg(in_dest_reg), .err_clr(err_clr),
        .wb_write_enb(wb_write_enb), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .wb_valid(wb_valid), .misalign_err(misalign_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic e, input logic [4:0] r,
                           input logic [31:0] d, input logic err, input logic [3:0] c);
        chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
        chk({tag, ".enb"}, {31'd0, wb_write_enb}, {31'd0, e});
        chk({tag, ".reg"}, {27'd0, wb_write_reg}, {27'd0, r});
        chk({tag, ".data"}, wb_write_data, d);
        chk({tag, ".err"}, {31'd0, misalign_err}, {31'd0, err});
        chk({tag, ".cnt"}, {28'd0, retire_count}, {28'd0, c});
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] dst);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_load_type = lt;
        in_addr_lo = lo; in_alu_result = alu; in_mem_rdata = rd; in_dest_reg = dst;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 5'd31);
        tick(); tick();
        chk_all("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd3, 32'h0000_1234, 32'hAAAA_AAAA, 5'd8);
        tick();
        chk_all("alu", 1'b1, 1'b1, 5'd8, 32'h0000_1234, 1'b0, 4'd1);
        drive(1'b1, 1'b1, 1'b1, 3'd1, 2'd1, 32'h0000_1001, 32'h1280_3456, 5'd9);
        tick();
        chk_all("lb", 1'b1, 1'b1, 5'd9, 32'hFFFF_FF80, 1'b0, 4'd2);
        in_load_type = 3'd2;
        tick();
        chk("lbu.data", wb_write_data, 32'h0000_0080);
        in_addr_lo = 2'd3;
        tick();
        chk("lbu3.data", wb_write_data, 32'h0000_0056);
        drive(1'b1, 1'b1, 1'b1, 3'd3, 2'd2, 32'h0000_1002, 32'h0000_8001, 5'd10);
        tick();
        chk_all("lh", 1'b1, 1'b1, 5'd10, 32'hFFFF_8001, 1'b0, 4'd5);
        in_load_type = 3'd4;
        tick();
        chk("lhu.data", wb_write_data, 32'h0000_8001);
        drive(1'b1, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0000_1000, 32'h8001_0000, 5'd10);
        tick();
        chk("lhu0.data", wb_write_data, 32'h0000_8001);
        drive(1'b1, 1'b1, 1'b1, 3'd6, 2'd0, 32'h0000_1000, 32'hCAFE_BABE, 5'd11);
        tick();
        chk_all("lw", 1'b1, 1'b1, 5'd11, 32'hCAFE_BABE, 1'b0, 4'd8);
        drive(1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0000_1002, 32'h1111_2222, 5'd12);
        tick();
        chk("lwmis.enb", {31'd0, wb_write_enb}, 32'd0);
        chk("lwmis.err", {31'd0, misalign_err}, 32'd1);
        chk("lwmis.cnt", {28'd0, retire_count}, 32'd9);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("errhold", {31'd0, misalign_err}, 32'd1);
        end
        chk("idle.cnt", {28'd0, retire_count}, 32'd9);
        err_clr = 1'b1;
        tick();
        chk("errclr", {31'd0, misalign_err}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0000_1001, 32'h0, 5'd13);
        tick();
        err_clr = 1'b0;
        chk("setwins.err", {31'd0, misalign_err}, 32'd1);
        chk("setwins.enb", {31'd0, wb_write_enb}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_DEAD, 32'h0, 5'd0);
        tick();
        chk_all("zero", 1'b1, 1'b0, 5'd0, 32'h0000_DEAD, 1'b1, 4'd11);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0055, 32'h0, 5'd5);
        tick();
        chk_all("prestall", 1'b1, 1'b1, 5'd5, 32'h0000_0055, 1'b1, 4'd12);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h100 + i, 32'h0, 5'(6 + i));
            tick();
            chk_all("stall", 1'b1, 1'b1, 5'd5, 32'h0000_0055, 1'b1, 4'd12);
        end
        flush = 1'b1;
        tick();
        chk_all("flush", 1'b0, 1'b0, 5'd5, 32'h0000_0055, 1'b1, 4'd12);
        stall = 1'b0; flush = 1'b0; rst = 1'b0;
        tick();
        chk_all("rst2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd1);
        for (int i = 0; i < 17; i++) tick();
        chk("wrap.cnt", {28'd0, retire_count}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 3'd5, 2'd3, 32'h0, 32'h0, 5'd2);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0033, 32'h0, 5'd3);
        tick();
        chk_all("pre", 1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 4'd3);
        stall = 1'b1;
        tick();
        chk_all("held", 1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 4'd3);
        rst = 1'b0;
        tick();
        chk_all("rststall", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
